sync_fifo_flags: RTL and testbench
==================================

# sync_fifo_flags

Parametrised synchronous first-word-fall-through FIFO, successor to the basic UART byte FIFO. It adds:
- an exported fill level
- programmable almost-full and almost-empty thresholds
- a synchronous flush
- optional sticky overflow/underflow error flags

It sits between the APB register file and the UART TX/RX shifters and serves both directions, with `DATA_WIDTH` covering data plus status bits.

## Interface
- `DATA_WIDTH`, 8, word width in bits (≥1)
- `ADDR_WIDTH`, 4, log2 of depth; `DEPTH = 2**ADDR_WIDTH` (≥2)
- `AFULL_THRESH`, `DEPTH-2`, `almost_full` asserts when `level >= AFULL_THRESH` (1..DEPTH)
- `AEMPTY_THRESH`, 1, `almost_empty` asserts when `level <= AEMPTY_THRESH` (0..DEPTH-1)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `flush` in 1: synchronous discard of all contents
- `wr_en` in 1: write request
- `din` in DATA_WIDTH: write data
- `rd_en` in 1: read/pop request
- `dout` out DATA_WIDTH: head word (FWFT); 0 when empty
- `full` out 1: `level == DEPTH`
- `empty` out 1: `level == 0`
- `almost_full` out 1: threshold flag
- `almost_empty` out 1: threshold flag
- `level` out ADDR_WIDTH+1: current occupancy, 0..DEPTH
- `err_clr` in 1: clears sticky error flags
- `overflow` out 1: sticky, write attempted while full
- `underflow` out 1: sticky, read attempted while empty

## Operation
- **Storage:** DEPTH×DATA_WIDTH array. Write and read pointers are ADDR_WIDTH bits and wrap naturally at DEPTH−1→0. The `level` register is ADDR_WIDTH+1 bits.
- **Write accept:** `wr_ok = wr_en & !full`. The array entry at `wr_ptr` is written and `wr_ptr` increments.
- **Read accept:** `rd_ok = rd_en & !empty`. `rd_ptr` increments.
- **Flag source:** `full` and `empty` come from the registered `level` value before the edge. A simultaneous read never frees room for a write in the same cycle.
  - Full with wr+rd: the read pops, the write is rejected, and the overflow event fires. `level` becomes DEPTH−1.
  - Empty with wr+rd: the write is accepted, the read is rejected, and the underflow event fires. `level` becomes 1.
  - Non-full, non-empty with wr+rd: both are accepted and `level` is unchanged.
- **Level update:** `level <= level + wr_ok − rd_ok`. Computed at ADDR_WIDTH+1 bits, never wraps.
- **Output data:** `dout = empty ? 0 : mem[rd_ptr]`, combinational from the registered pointer and level.
- **Threshold flags:** `almost_full = (level >= AFULL_THRESH)`, `almost_empty = (level <= AEMPTY_THRESH)`, combinational from registered `level`.
- **Flush:** clears `wr_ptr`, `rd_ptr` and `level` to 0 on the next edge. It has priority over `wr_en` and `rd_en` in the same cycle, and those requests are dropped with no error events. Array contents are not cleared. Flush does not clear the error flags.
- **Error flags:** set on the edge of an offending attempt and hold until `err_clr` or `rst`. If `err_clr` and a new event occur in the same cycle, the set wins.
- **Reset:** `rst` has priority over everything and clears pointers, `level` and error flags. The array is not reset. Reset mid-transfer discards all contents.

## Timing
- **Reset values of outputs:** `dout`=0, `empty`=1, `full`=0, `level`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0.
- **Write-to-read latency:** 1 cycle. A word written at edge N appears on `dout`, with `empty`=0, after edge N and can be popped at edge N+1.
- **Pop:** the next word appears on `dout` immediately after the popping edge.
- **Flag latency:** all status flags update on the same edge as `level`. There is no extra pipeline stage.
- **Flush and reset:** take effect at the edge where they are sampled high. Outputs show reset values after that edge, except that flush leaves the error flags unchanged.

## Configuration
- **Macro:** `SYNC_FIFO_ERR_FLAGS_EN`.
- **Defined:** the overflow/underflow sticky registers and `err_clr` logic are built as described.
- **Undefined:**
  - `overflow` and `underflow` are tied to 0.
  - `err_clr` is ignored.
  - No error registers are instantiated.
  - All other behaviour is identical.

## Test plan
- **Reset and fill:** after reset, write 0x01..0x10 (DATA_WIDTH=8, ADDR_WIDTH=4).
  - `full` rises after the 16th write and `level`=16.
  - `almost_full` rises when `level`=14.
  - `dout`=0x01 throughout.
- **Drain and wrap:** pop 16 words.
  - `dout` sequence is 0x01..0x10, then `empty`=1 and `dout`=0.
  - Refill 20 words with 4 pops interleaved to exercise pointer wrap; read order stays FIFO.
- **Simultaneous at full:** with the FIFO full, apply wr+rd of 0xAA.
  - The head pops and 0xAA is dropped.
  - `level`=15 and `overflow`=1 (macro on) or 0 (macro off).
- **Simultaneous at empty:** with the FIFO empty, apply wr 0x55 + rd.
  - `level`=1, `dout`=0x55, `underflow`=1.
  - `err_clr` pulse then gives `underflow`=0.
- **Flush priority:** with `level`=5, assert flush+wr+rd.
  - Next cycle: `level`=0, `empty`=1, `almost_empty`=1, no error flags set.
  - A following write of 0x77 appears on `dout` one cycle later.
- **Mid-operation reset:** assert `rst` with `level`=9 and wr active.
  - All outputs return to reset values after the edge and the write is discarded.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: parametrised first-word-fall-through FIFO with fill level,
// programmable almost-full/almost-empty thresholds, synchronous flush and
// optional sticky overflow/underflow flags (built when SYNC_FIFO_ERR_FLAGS_EN
// is defined; otherwise both flags read 0 and err_clr is ignored).
module sync_fifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LVL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level_q;
  logic                  wr_ok;
  logic                  rd_ok;

  // Flags come from the registered level, so a same-cycle read never makes
  // room for a write and a same-cycle write never feeds a read.
  assign full         = (level_q == DEPTH_LVL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AFULL_LVL);
  assign almost_empty = (level_q <= AEMPTY_LVL);
  assign level        = level_q;
  assign wr_ok        = wr_en & ~full;
  assign rd_ok        = rd_en & ~empty;
  assign dout         = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; reset beats flush, flush beats requests.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array has no reset; only accepted writes land in it.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_ok) mem[wr_ptr] <= din;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_evt;
  logic udf_evt;
  logic overflow_q;
  logic underflow_q;

  // A flushed cycle drops its requests silently, so it raises no events.
  assign ovf_evt   = wr_en & full  & ~flush;
  assign udf_evt   = rd_en & empty & ~flush;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Sticky error flags; a new event in the clearing cycle wins over err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (err_clr) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      if (ovf_evt) overflow_q  <= 1'b1;
      if (udf_evt) underflow_q <= 1'b1;
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed plus randomized bench for sync_fifo_flags,
// compared every cycle against a queue-based reference model.
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   level;
  logic          err_clr;
  logic          overflow;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] modelQ[$];
  bit            modelOvf;
  bit            modelUdf;

  sync_fifo_flags #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .wr_en(wr_en),
    .din(din),
    .rd_en(rd_en),
    .dout(dout),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .level(level),
    .err_clr(err_clr),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge, derived from the occupancy rules.
  task automatic modelStep(input bit r, input bit f, input bit w, input logic [DW-1:0] d,
                           input bit rd, input bit clr);
    bit wasFull;
    bit wasEmpty;
    if (r) begin
      modelQ.delete();
      modelOvf = 0;
      modelUdf = 0;
    end else if (f) begin
      modelQ.delete();
    end else begin
      wasFull  = (modelQ.size() == DEPTH);
      wasEmpty = (modelQ.size() == 0);
      if (clr) begin
        modelOvf = 0;
        modelUdf = 0;
      end
      if (w && wasFull)   modelOvf = ERR_EN;
      if (rd && wasEmpty) modelUdf = ERR_EN;
      if (rd && !wasEmpty) void'(modelQ.pop_front());
      if (w && !wasFull)   modelQ.push_back(d);
    end
  endtask

  task automatic compareAll();
    int unsigned n;
    n = modelQ.size();
    checkOutput("level", level, n);
    checkOutput("empty", empty, n == 0);
    checkOutput("full", full, n == DEPTH);
    checkOutput("almost_full", almost_full, n >= DEPTH - 2);
    checkOutput("almost_empty", almost_empty, n <= 1);
    checkOutput("dout", dout, (n == 0) ? 0 : modelQ[0]);
    checkOutput("overflow", overflow, modelOvf);
    checkOutput("underflow", underflow, modelUdf);
  endtask

  task automatic applyStimulus(input bit r, input bit f, input bit w, input logic [DW-1:0] d,
                               input bit rd, input bit clr);
    @(negedge clk);
    rst = r; flush = f; wr_en = w; din = d; rd_en = rd; err_clr = clr;
    @(posedge clk);
    modelStep(r, f, w, d, rd, clr);
    #1;
    compareAll();
  endtask

  initial begin
    rst = 1; flush = 0; wr_en = 0; din = '0; rd_en = 0; err_clr = 0;
    modelQ.delete();
    modelOvf = 0;
    modelUdf = 0;

    applyStimulus(1, 0, 0, 8'h00, 0, 0);
    applyStimulus(1, 0, 0, 8'h00, 0, 0);
    checkOutput("reset_level", level, 0);
    checkOutput("reset_empty", empty, 1);
    checkOutput("reset_dout", dout, 0);

    // Fill with 0x01..0x10; head stays 0x01 the whole time.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(0, 0, 1, DW'(i), 0, 0);
      checkOutput("fill_head", dout, 8'h01);
      checkOutput("fill_afull", almost_full, i >= 14);
    end
    checkOutput("fill_full", full, 1);
    checkOutput("fill_level", level, 16);

    // Drain in order.
    for (int i = 1; i <= 16; i++) begin
      checkOutput("drain_head", dout, DW'(i));
      applyStimulus(0, 0, 0, 8'h00, 1, 0);
    end
    checkOutput("drain_empty", empty, 1);
    checkOutput("drain_dout", dout, 0);

    // Refill 20 words with 4 interleaved pops so both pointers wrap.
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 0, 1, DW'(8'h20 + i), (i % 5) == 3, 0);
    checkOutput("wrap_full", full, 1);
    checkOutput("wrap_head", dout, 8'h24);

    // Write+read at full: head pops, 0xAA dropped, overflow event.
    applyStimulus(0, 0, 1, 8'hAA, 1, 0);
    checkOutput("ovf_level", level, 15);
    checkOutput("ovf_flag", overflow, ERR_EN);
    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 8'h00, 1, 0);
    checkOutput("ovf_drained", empty, 1);

    // Write+read at empty: write lands, read rejected, underflow event.
    applyStimulus(0, 0, 1, 8'h55, 1, 0);
    checkOutput("udf_level", level, 1);
    checkOutput("udf_dout", dout, 8'h55);
    checkOutput("udf_flag", underflow, ERR_EN);
    applyStimulus(0, 0, 0, 8'h00, 0, 1);
    checkOutput("clr_udf", underflow, 0);
    checkOutput("clr_ovf", overflow, 0);

    // Flush priority at level 5.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, DW'(8'h60 + i), 0, 0);
    checkOutput("pre_flush_level", level, 5);
    applyStimulus(0, 1, 1, 8'h99, 1, 0);
    checkOutput("flush_level", level, 0);
    checkOutput("flush_aempty", almost_empty, 1);
    checkOutput("flush_no_udf", underflow, 0);
    applyStimulus(0, 0, 1, 8'h77, 0, 0);
    checkOutput("post_flush_dout", dout, 8'h77);

    // Reset mid-transfer at level 9 with a write active.
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, DW'(8'h80 + i), 0, 0);
    checkOutput("pre_rst_level", level, 9);
    applyStimulus(1, 0, 1, 8'hEE, 0, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_dout", dout, 0);

    // Randomized traffic in phases biased toward filling or draining.
    for (int i = 0; i < 800; i++) begin
      int unsigned wp;
      wp = ((i / 60) % 2 == 0) ? 80 : 25;
      applyStimulus($urandom_range(0, 399) == 0,
                    $urandom_range(0, 99) == 0,
                    $urandom_range(0, 99) < wp,
                    DW'($urandom),
                    $urandom_range(0, 99) < (105 - wp),
                    $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
